id_ex_stage: RTL

//   ID/EX pipeline register plus load-use hazard detection for the 5-stage pipelined core.

---
 rtl/id_ex_if.sv | 50 +++++
 rtl/id_ex_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bus.
//   Decode side -> stage : inst_id, pc_id, read_data1_id, read_data2_id,
//                          imm_out_id, ctrl_id, flush
//   Stage -> execute/hazard consumers : inst_ex, pc_ex, read_data1_ex,
//                          read_data2_ex, imm_out_ex, rs1_ex, rs2_ex, rd_ex,
//                          ctrl_ex, ALUOp_ex, ALUSrc_ex, PCWrite, IFIDWrite,
//                          stall_count
// modport master : the decode/execute environment around the stage
// modport slave  : the id_ex_stage itself
interface id_ex_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [31:0]      inst_id;
    logic [XLEN-1:0]  pc_id;
    logic [XLEN-1:0]  read_data1_id;
    logic [XLEN-1:0]  read_data2_id;
    logic [XLEN-1:0]  imm_out_id;
    logic [7:0]       ctrl_id;
    logic             flush;

    logic [31:0]      inst_ex;
    logic [XLEN-1:0]  pc_ex;
    logic [XLEN-1:0]  read_data1_ex;
    logic [XLEN-1:0]  read_data2_ex;
    logic [XLEN-1:0]  imm_out_ex;
    logic [4:0]       rs1_ex;
    logic [4:0]       rs2_ex;
    logic [4:0]       rd_ex;
    logic [7:0]       ctrl_ex;
    logic [1:0]       ALUOp_ex;
    logic             ALUSrc_ex;
    logic             PCWrite;
    logic             IFIDWrite;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output inst_id, pc_id, read_data1_id, read_data2_id, imm_out_id, ctrl_id, flush,
        input  inst_ex, pc_ex, read_data1_ex, read_data2_ex, imm_out_ex,
               rs1_ex, rs2_ex, rd_ex, ctrl_ex, ALUOp_ex, ALUSrc_ex,
               PCWrite, IFIDWrite, stall_count
    );

    modport slave (
        input  inst_id, pc_id, read_data1_id, read_data2_id, imm_out_id, ctrl_id, flush,
        output inst_ex, pc_ex, read_data1_ex, read_data2_ex, imm_out_ex,
               rs1_ex, rs2_ex, rd_ex, ctrl_ex, ALUOp_ex, ALUSrc_ex,
               PCWrite, IFIDWrite, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : id_ex_if slave; decode-stage inputs (*_id, flush) in,
//                registered execute-stage fields (*_ex), PCWrite/IFIDWrite
//                stall controls and the stall performance counter out.
// ctrl packing: {RegWrite,MemRead,MemWrite,MemtoReg,Branch,ALUSrc,ALUOp[1:0]}
module id_ex_stage #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    localparam int CTRL_MEM_READ = 6;
    localparam int CTRL_ALU_SRC  = 2;

    logic [31:0]      inst_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  rd1_q;
    logic [XLEN-1:0]  rd2_q;
    logic [XLEN-1:0]  imm_q;
    logic [7:0]       ctrl_q;
    logic [CNT_W-1:0] cnt_q;

    logic [6:0] op;
    logic [4:0] rd_q;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hazard;
    logic       stall;

    assign op   = bus.inst_id[6:0];
    assign rd_q = inst_q[11:7];

    // Which source registers the decode-stage instruction actually reads;
    // I-type immediates overlap the rs2 field and must not match.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (op)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LOAD:  uses_rs1 = 1'b1;
            default:  ;
        endcase
    end

    // A bubble has rd=0 and MemRead=0, so it can never re-trigger a stall.
    assign hazard = ctrl_q[CTRL_MEM_READ] && (rd_q != 5'd0) &&
                    ((uses_rs1 && (rd_q == bus.inst_id[19:15])) ||
                     (uses_rs2 && (rd_q == bus.inst_id[24:20])));

    // A flush squashes the dependent instruction anyway, so it suppresses the stall.
    assign stall = hazard && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            inst_q <= NOP_INST;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else if (bus.flush || stall) begin
            inst_q <= NOP_INST;
            pc_q   <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            ctrl_q <= '0;
            // Only load-use bubbles are counted; the counter saturates.
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            inst_q <= bus.inst_id;
            pc_q   <= bus.pc_id;
            rd1_q  <= bus.read_data1_id;
            rd2_q  <= bus.read_data2_id;
            imm_q  <= bus.imm_out_id;
            ctrl_q <= bus.ctrl_id;
        end
    end

    assign bus.inst_ex       = inst_q;
    assign bus.pc_ex         = pc_q;
    assign bus.read_data1_ex = rd1_q;
    assign bus.read_data2_ex = rd2_q;
    assign bus.imm_out_ex    = imm_q;
    assign bus.rs1_ex        = inst_q[19:15];
    assign bus.rs2_ex        = inst_q[24:20];
    assign bus.rd_ex         = rd_q;
    assign bus.ctrl_ex       = ctrl_q;
    assign bus.ALUOp_ex      = ctrl_q[1:0];
    assign bus.ALUSrc_ex     = ctrl_q[CTRL_ALU_SRC];
    assign bus.PCWrite       = !stall;
    assign bus.IFIDWrite     = !stall;
    assign bus.stall_count   = cnt_q;
endmodule
